link_seq_ctrl: RTL and testbench
================================

Name: link_seq_ctrl

Overview:
- Sequencer for the PRBS9 + BPSK + RC + BER chain.
- Generates the baud-rate TX valid strobe that enables the PRBS9 and RC filter, and the RX decimation strobe at a selectable phase.
- Runs the BER alignment search: picks the reference-delay tap with the fewest errors, then accumulates bit and error counts for the board LEDs/readout.
- Sits in the top level beside the datapath; the external delay line and XOR comparator are configured by o_delay_sel.

Parameters:
OS, 4, oversampling factor; clocks per baud (power of 2, ≥2)
NDELAY, 16, number of candidate reference delays searched (taps 0..NDELAY-1)
DLY_W, 4, width of o_delay_sel (ceil log2 NDELAY)
SYNC_LEN, 511, RX bits counted per candidate during search (one PRBS9 period)
CNT_W, 64, width of bit/error accumulators

Ports:
clock  in  1  system clock
i_reset  in  1  reset, asynchronous, active-low
i_tx_en  in  1  TX enable (switch 0); freezes baud counter when low
i_rx_en  in  1  RX enable (switch 1)
i_phase  in  log2(OS)  RX sampling offset within baud (switches 3:2)
i_err  in  1  rx_bit XOR delayed reference bit; sampled only on cycles with o_rx_valid=1
o_tx_valid  out  1  one-clock strobe per baud to PRBS9/filter
o_rx_valid  out  1  one-clock RX sample strobe
o_delay_sel  out  DLY_W  reference delay tap select (combinational tap mux outside, no settle time)
o_locked  out  1  search complete, measuring
o_bit_cnt  out  CNT_W  bits measured while locked
o_err_cnt  out  CNT_W  errors measured while locked
o_ber_zero  out  1  o_locked & o_bit_cnt!=0 & o_err_cnt==0

Behaviour:
- Reset (i_reset=0, async): all outputs 0, baud counter 0, state IDLE, best_err = all ones, best_d = 0.
- Baud counter bc (log2(OS) bits): when i_tx_en=1, bc wraps OS-1 -> 0; when i_tx_en=0, it and the strobes hold.
- o_tx_valid registered: asserted the cycle after bc==0 while i_tx_en=1; exactly one pulse per OS clocks.
- o_rx_valid registered: asserted the cycle after bc==i_phase while i_tx_en=1 and i_rx_en=1.
- FSM states:
  - IDLE: o_locked=0. When i_rx_en=1, clear bit_cnt/err_cnt, set d=0, best_err=max, best_d=0, and go to SEARCH.
  - SEARCH: o_delay_sel=d. Per o_rx_valid, increment the window count wc and add i_err to werr. When wc reaches SYNC_LEN (that last strobe included):
    - if werr < best_err (strict), set best_err=werr and best_d=d; ties keep the lower d;
    - clear wc/werr; if d==NDELAY-1, go to LOCK, else d++.
  - LOCK: o_delay_sel=best_d, o_locked=1. Per o_rx_valid, bit_cnt++ and err_cnt += i_err. Both counters saturate at all ones.
- Leaving an active state:
  - i_rx_en falling, in any state: go to IDLE next cycle; o_locked drops; counters hold their last values for readout.
  - i_phase change while in SEARCH or LOCK: restart as on entry from IDLE (counters cleared, d=0).
- Strobe vs. FSM transition in the same cycle: the strobe is counted in the old state's accounting; the restart takes priority over accumulation.
- Search latency: NDELAY*SYNC_LEN RX strobes (16*511*4 = 32704 clocks at defaults).

Test Plan:
- Reset release, i_tx_en=1, i_rx_en=0 -> o_tx_valid pulses every 4 clocks starting 1 clock after bc==0; o_rx_valid stays 0; all counts 0.
- i_rx_en=1, i_phase=2 -> o_rx_valid pulses 2 clocks after each o_tx_valid; a mid-run i_tx_en=0 freezes both strobes, and resuming continues the same spacing.
- i_err model: error-free at tap 5, random (about 50%) elsewhere -> after 16*511 strobes o_locked=1 and o_delay_sel=5; after 1000 further strobes o_bit_cnt=1000, o_err_cnt=0, o_ber_zero=1.
- Taps 3 and 7 both error-free -> o_delay_sel=3 (tie keeps the lower tap); injecting 3 errors after lock -> o_err_cnt=3, o_ber_zero=0.
- Change i_phase mid-search, and separately mid-lock -> o_locked=0 and counts cleared next cycle; a full search is re-run from d=0.
- Drop i_rx_en while locked -> IDLE, counts held; assert i_reset=0 asynchronously mid-search -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/link_seq_ctrl.sv
// Link sequencer: baud/RX strobes, BER reference-delay alignment search and
// locked bit/error accumulation for the PRBS9 + BPSK + RC + BER chain.
module link_seq_ctrl #(
  parameter  int OS       = 4,
  parameter  int NDELAY   = 16,
  parameter  int DLY_W    = 4,
  parameter  int SYNC_LEN = 511,
  parameter  int CNT_W    = 64,
  localparam int PH_W     = $clog2(OS)
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_tx_en,
  input  logic             i_rx_en,
  input  logic [PH_W-1:0]  i_phase,
  input  logic             i_err,
  output logic             o_tx_valid,
  output logic             o_rx_valid,
  output logic [DLY_W-1:0] o_delay_sel,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_ber_zero,
  output logic [1:0]       o_state
);

  localparam int WC_W = $clog2(SYNC_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_LOCK   = 2'd2
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   bc;
  logic [PH_W-1:0]   phase_q;
  logic [DLY_W-1:0]  d;
  logic [DLY_W-1:0]  best_d;
  logic [WC_W-1:0]   best_err;
  logic [WC_W-1:0]   wc;
  logic [WC_W-1:0]   werr;

  logic [WC_W-1:0]   wc_nxt;
  logic [WC_W-1:0]   werr_nxt;
  logic              win_done;
  logic              better;
  logic              restart;
  logic [CNT_W-1:0]  bit_cnt_nxt;
  logic [CNT_W-1:0]  err_cnt_nxt;

  // Handshake: o_tx_valid / o_rx_valid are one-cycle strobes with no ready;
  // i_err is meaningful only in a cycle where o_rx_valid is high.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      bc         <= '0;
      o_tx_valid <= 1'b0;
      o_rx_valid <= 1'b0;
    end else begin
      o_tx_valid <= i_tx_en && (bc == '0);
      o_rx_valid <= i_tx_en && i_rx_en && (bc == i_phase);
      if (i_tx_en) bc <= bc + PH_W'(1);
    end
  end

  always_comb begin
    wc_nxt      = wc + WC_W'(1);
    werr_nxt    = werr + WC_W'(i_err);
    win_done    = (wc_nxt == WC_W'(SYNC_LEN));
    better      = (werr_nxt < best_err);
    restart     = i_rx_en && ((state == S_IDLE) || (i_phase != phase_q));
    bit_cnt_nxt = (&o_bit_cnt) ? o_bit_cnt : o_bit_cnt + CNT_W'(1);
    err_cnt_nxt = (i_err && !(&o_err_cnt)) ? o_err_cnt + CNT_W'(1) : o_err_cnt;
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      phase_q     <= '0;
      d           <= '0;
      best_d      <= '0;
      best_err    <= '1;
      wc          <= '0;
      werr        <= '0;
      o_delay_sel <= '0;
      o_locked    <= 1'b0;
      o_bit_cnt   <= '0;
      o_err_cnt   <= '0;
    end else begin
      phase_q <= i_phase;
      // A strobe landing on the cycle LOCK is left still counts.
      if (state == S_LOCK && o_rx_valid) begin
        o_bit_cnt <= bit_cnt_nxt;
        o_err_cnt <= err_cnt_nxt;
      end
      if (!i_rx_en) begin
        state    <= S_IDLE;
        o_locked <= 1'b0;
      end else if (restart) begin
        state       <= S_SEARCH;
        o_locked    <= 1'b0;
        o_bit_cnt   <= '0;
        o_err_cnt   <= '0;
        d           <= '0;
        o_delay_sel <= '0;
        best_err    <= '1;
        best_d      <= '0;
        wc          <= '0;
        werr        <= '0;
      end else if (state == S_SEARCH && o_rx_valid) begin
        if (win_done) begin
          wc   <= '0;
          werr <= '0;
          if (better) begin
            best_err <= werr_nxt;
            best_d   <= d;
          end
          if (d == DLY_W'(NDELAY - 1)) begin
            state       <= S_LOCK;
            o_locked    <= 1'b1;
            o_delay_sel <= better ? d : best_d;
          end else begin
            d           <= d + DLY_W'(1);
            o_delay_sel <= d + DLY_W'(1);
          end
        end else begin
          wc   <= wc_nxt;
          werr <= werr_nxt;
        end
      end
    end
  end

  assign o_ber_zero = o_locked && (o_bit_cnt != '0) && (o_err_cnt == '0);
  assign o_state    = state;

endmodule

// File: tb/tb_link_seq_ctrl.sv
// Bench for link_seq_ctrl: strobe vector table, per-cycle reference model with
// per-tap window error arrays, and directed search/lock/restart/reset sequences.
module tb_link_seq_ctrl;

  localparam int OS       = 4;
  localparam int NDELAY   = 16;
  localparam int SYNC_LEN = 511;
  localparam int WIN_MAX  = 511;  // all-ones of the 9-bit window error count

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_LOCK   = 2;

  logic        clock = 1'b0;
  logic        i_reset;
  logic        i_tx_en;
  logic        i_rx_en;
  logic [1:0]  i_phase;
  logic        i_err;
  logic        o_tx_valid;
  logic        o_rx_valid;
  logic [3:0]  o_delay_sel;
  logic        o_locked;
  logic [63:0] o_bit_cnt;
  logic [63:0] o_err_cnt;
  logic        o_ber_zero;
  logic [1:0]  o_state;

  link_seq_ctrl dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_tx_en     (i_tx_en),
    .i_rx_en     (i_rx_en),
    .i_phase     (i_phase),
    .i_err       (i_err),
    .o_tx_valid  (o_tx_valid),
    .o_rx_valid  (o_rx_valid),
    .o_delay_sel (o_delay_sel),
    .o_locked    (o_locked),
    .o_bit_cnt   (o_bit_cnt),
    .o_err_cnt   (o_err_cnt),
    .o_ber_zero  (o_ber_zero),
    .o_state     (o_state)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int              m_state;
  int              m_bc;
  bit              m_tx_valid;
  bit              m_rx_valid;
  int              m_d;
  int              m_dsel;
  bit              m_locked;
  longint unsigned m_bit;
  longint unsigned m_err;
  int              m_phase_prev;
  int              m_tap_err[NDELAY];
  int              m_tap_n[NDELAY];

  bit clean[NDELAY];
  int inj_left;
  int lock_strobes;

  typedef struct {
    logic       tx_en;
    logic       rx_en;
    logic [1:0] phase;
    logic       exp_tx;
    logic       exp_rx;
  } vec_t;
  vec_t vecs[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_bc = 0; m_tx_valid = 0; m_rx_valid = 0;
    m_d = 0; m_dsel = 0; m_locked = 0; m_bit = 0; m_err = 0; m_phase_prev = 0;
    for (int i = 0; i < NDELAY; i++) begin m_tap_err[i] = 0; m_tap_n[i] = 0; end
  endtask

  task automatic model_start();
    m_state = M_SEARCH; m_locked = 0; m_bit = 0; m_err = 0; m_d = 0; m_dsel = 0;
    for (int i = 0; i < NDELAY; i++) begin m_tap_err[i] = 0; m_tap_n[i] = 0; end
  endtask

  function automatic int pick_best();
    int be = WIN_MAX;
    int bd = 0;
    for (int i = 0; i < NDELAY; i++)
      if (m_tap_err[i] < be) begin be = m_tap_err[i]; bd = i; end
    return bd;
  endfunction

  task automatic model_edge();
    bit rxv = m_rx_valid;
    if (m_state == M_LOCK && rxv) begin
      if (m_bit != 64'hFFFF_FFFF_FFFF_FFFF) m_bit++;
      if (i_err && m_err != 64'hFFFF_FFFF_FFFF_FFFF) m_err++;
    end
    if (!i_rx_en) begin
      m_state = M_IDLE; m_locked = 0;
    end else if (m_state == M_IDLE || int'(i_phase) != m_phase_prev) begin
      model_start();
    end else if (m_state == M_SEARCH && rxv) begin
      m_tap_err[m_d] += int'(i_err);
      m_tap_n[m_d]++;
      if (m_tap_n[m_d] == SYNC_LEN) begin
        if (m_d == NDELAY - 1) begin
          m_dsel = pick_best(); m_state = M_LOCK; m_locked = 1;
        end else begin
          m_d++; m_dsel = m_d;
        end
      end
    end
    m_tx_valid = i_tx_en && (m_bc == 0);
    m_rx_valid = i_tx_en && i_rx_en && (m_bc == int'(i_phase));
    if (i_tx_en) m_bc = (m_bc + 1) % OS;
    m_phase_prev = int'(i_phase);
  endtask

  task automatic check_all();
    chk("tx_valid",  64'(o_tx_valid),  64'(m_tx_valid));
    chk("rx_valid",  64'(o_rx_valid),  64'(m_rx_valid));
    chk("delay_sel", 64'(o_delay_sel), 64'(m_dsel));
    chk("locked",    64'(o_locked),    64'(m_locked));
    chk("bit_cnt",   o_bit_cnt,        m_bit);
    chk("err_cnt",   o_err_cnt,        m_err);
    chk("ber_zero",  64'(o_ber_zero),  64'(m_locked && m_bit != 0 && m_err == 0));
  endtask

  // One clock: drive i_err, let the edge happen, advance model, check at negedge.
  task automatic tick();
    i_err = clean[m_dsel] ? 1'b0 : 1'($urandom_range(0, 1));
    if (inj_left > 0 && m_rx_valid && m_state == M_LOCK) begin
      i_err = 1'b1; inj_left--;
    end
    if (m_rx_valid && m_state == M_LOCK) lock_strobes++;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic wait_lock(input string name);
    int n = 0;
    while (!o_locked && n < 40000) begin tick(); n++; end
    chk(name, 64'(o_locked), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 1'b0, 2'd2, (i % 4 == 0), 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b1};

    for (int i = 0; i < NDELAY; i++) clean[i] = 0;
    clean[5] = 1;
    inj_left = 0; lock_strobes = 0;
    i_tx_en = 0; i_rx_en = 0; i_phase = 2'd2; i_err = 0;
    model_reset();

    // Reset state
    i_reset = 1'b1;
    #2 i_reset = 1'b0;
    #2;
    chk("rst_tx_valid", 64'(o_tx_valid), 64'd0);
    chk("rst_rx_valid", 64'(o_rx_valid), 64'd0);
    chk("rst_locked",   64'(o_locked),   64'd0);
    chk("rst_bit_cnt",  o_bit_cnt,       64'd0);
    chk("rst_err_cnt",  o_err_cnt,       64'd0);
    @(negedge clock);
    i_reset = 1'b1;

    // Strobe spacing, RX phase offset and TX freeze
    for (int i = 0; i < 22; i++) begin
      i_tx_en = vecs[i].tx_en; i_rx_en = vecs[i].rx_en; i_phase = vecs[i].phase;
      tick();
      chk($sformatf("vec%0d_tx", i), 64'(o_tx_valid), 64'(vecs[i].exp_tx));
      chk($sformatf("vec%0d_rx", i), 64'(o_rx_valid), 64'(vecs[i].exp_rx));
    end

    // Phase change mid-search restarts from tap 0
    repeat (2000) tick();
    i_phase = 2'd1;
    tick();
    chk("midsearch_locked", 64'(o_locked),    64'd0);
    chk("midsearch_dsel",   64'(o_delay_sel), 64'd0);
    chk("midsearch_bits",   o_bit_cnt,        64'd0);

    // Full search, only tap 5 error-free
    wait_lock("lock_tap5");
    chk("lock_tap5_dsel", 64'(o_delay_sel), 64'd5);
    lock_strobes = 0;
    while (lock_strobes < 1000) tick();
    chk("tap5_bits",     o_bit_cnt,        64'd1000);
    chk("tap5_errs",     o_err_cnt,        64'd0);
    chk("tap5_ber_zero", 64'(o_ber_zero),  64'd1);

    // Phase change mid-lock; taps 3 and 7 both clean
    clean[5] = 0; clean[3] = 1; clean[7] = 1;
    i_phase = 2'd3;
    tick();
    chk("midlock_locked", 64'(o_locked), 64'd0);
    chk("midlock_bits",   o_bit_cnt,     64'd0);
    chk("midlock_errs",   o_err_cnt,     64'd0);
    wait_lock("lock_tie");
    chk("lock_tie_dsel", 64'(o_delay_sel), 64'd3);
    lock_strobes = 0;
    inj_left = 3;
    while (lock_strobes < 50) tick();
    chk("inj_bits",     o_bit_cnt,       64'd50);
    chk("inj_errs",     o_err_cnt,       64'd3);
    chk("inj_ber_zero", 64'(o_ber_zero), 64'd0);

    // RX disable while locked: IDLE, counts held
    i_rx_en = 1'b0;
    repeat (20) tick();
    chk("drop_locked", 64'(o_locked), 64'd0);
    chk("drop_bits",   o_bit_cnt,     64'd50);
    chk("drop_errs",   o_err_cnt,     64'd3);

    // Async reset mid-search, between clock edges
    i_rx_en = 1'b1;
    repeat (300) tick();
    #2 i_reset = 1'b0;
    #1;
    chk("areset_tx_valid", 64'(o_tx_valid),  64'd0);
    chk("areset_rx_valid", 64'(o_rx_valid),  64'd0);
    chk("areset_dsel",     64'(o_delay_sel), 64'd0);
    chk("areset_locked",   64'(o_locked),    64'd0);
    chk("areset_bits",     o_bit_cnt,        64'd0);
    chk("areset_errs",     o_err_cnt,        64'd0);
    chk("areset_ber_zero", 64'(o_ber_zero),  64'd0);
    model_reset();
    @(negedge clock);
    i_reset = 1'b1;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
